// File: rtl/rv32m_seq_divider.sv
// RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit per cycle; doneD pulses 34 cycles after start.
// Optional early-out for trivial operands is enabled with `define RV32M_DIV_EARLY_OUT_EN.
module rv32m_seq_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startD,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            busy,
  output logic            doneD,
  output logic [XLEN-1:0] result_divide
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [1:0]      op_q;
  logic            sq_q;
  logic            sr_q;
  logic            special_q;
  logic [XLEN-1:0] spec_res_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic            in_signed;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            sgn_ovf;
  logic            special_in;
  logic [XLEN-1:0] spec_val;

  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] dvd_d;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_res_d;

  // Operand decode at the start edge: magnitudes and the RISC-V special cases.
  always_comb begin
    in_signed  = ~div_opcode[0];
    a_mag      = (in_signed && operand1[XLEN-1]) ? -operand1 : operand1;
    b_mag      = (in_signed && operand2[XLEN-1]) ? -operand2 : operand2;
    div_zero   = (operand2 == '0);
    sgn_ovf    = in_signed && (operand1 == {1'b1, {(XLEN-1){1'b0}}}) && (operand2 == '1);
    special_in = div_zero | sgn_ovf;
    if (div_zero) begin
      spec_val = div_opcode[1] ? operand1 : '1;
    end else begin
      spec_val = div_opcode[1] ? '0 : operand1;
    end
  end

`ifdef RV32M_DIV_EARLY_OUT_EN
  logic            early_in;
  logic [XLEN-1:0] early_val;

  // |a| < |b| means quotient 0 and remainder is the untouched dividend.
  always_comb begin
    early_in  = special_in | (a_mag < b_mag);
    early_val = special_in ? spec_val : (div_opcode[1] ? operand1 : '0);
  end
`endif

  // One restoring step; the shifted partial remainder is one bit wider so the compare is exact.
  always_comb begin
    rem_sh = {rem_q, dvd_q[XLEN-1]};
    rem_ge = (rem_sh >= {1'b0, dvs_q});
    rem_d  = rem_ge ? (rem_sh[XLEN-1:0] - dvs_q) : rem_sh[XLEN-1:0];
    dvd_d  = {dvd_q[XLEN-2:0], rem_ge};
  end

  always_comb begin
    quo_fix = sq_q ? -dvd_q : dvd_q;
    rem_fix = sr_q ? -rem_q : rem_q;
    if (special_q) begin
      fix_res_d = spec_res_q;
    end else begin
      fix_res_d = op_q[1] ? rem_fix : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      sq_q       <= 1'b0;
      sr_q       <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (startD) begin
            op_q       <= div_opcode;
            sq_q       <= in_signed & (operand1[XLEN-1] ^ operand2[XLEN-1]);
            sr_q       <= in_signed & operand1[XLEN-1];
            special_q  <= special_in;
            spec_res_q <= spec_val;
            rem_q      <= '0;
            dvd_q      <= a_mag;
            dvs_q      <= b_mag;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
`ifdef RV32M_DIV_EARLY_OUT_EN
            if (early_in) begin
              result_q <= early_val;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
`else
            state_q    <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= fix_res_d;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign doneD         = done_q;
  assign result_divide = result_q;

endmodule

// File: tb/tb_rv32m_seq_divider.sv
// Bench for rv32m_seq_divider: driver pushes reference results, a monitor pops them on each doneD pulse.
module tb_rv32m_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        startD;
  logic [1:0]  div_opcode;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic        busy;
  logic        doneD;
  logic [31:0] result_divide;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

`ifdef RV32M_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  rv32m_seq_divider #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .startD       (startD),
    .div_opcode   (div_opcode),
    .operand1     (operand1),
    .operand2     (operand2),
    .busy         (busy),
    .doneD        (doneD),
    .result_divide(result_divide)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // RISC-V division semantics written with plain integer arithmetic (truncating toward zero).
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma;
    logic [31:0] mb;
    bit          trivial;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    trivial = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
    return (EARLY && trivial) ? 1 : 34;
  endfunction

  // Monitor: every doneD pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (doneD) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got doneD=1 with result 0x%08h, required no pending op", result_divide);
      end else begin
        check("result", result_divide, exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input string tag);
    int          n;
    int          lat;
    logic [31:0] expv;
    expv = ref_result(op, a, b);
    lat  = ref_latency(op, a, b);
    @(negedge clk);
    div_opcode = op;
    operand1   = a;
    operand2   = b;
    startD     = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    startD     = 1'b0;
    operand1   = $urandom;
    operand2   = $urandom;
    div_opcode = 2'($urandom_range(0, 3));
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    n = 1;
    while (!doneD && n < 100) begin
      if (n == poke_at) begin
        startD   = 1'b1;
        operand1 = $urandom;
        operand2 = $urandom;
      end
      @(posedge clk);
      #1;
      startD = 1'b0;
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse_end"}, 32'(doneD), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_result_held"}, result_divide, expv);
  endtask

  task automatic reset_abort();
    @(negedge clk);
    div_opcode = 2'b01;
    operand1   = 32'd1000;
    operand2   = 32'd7;
    startD     = 1'b1;
    @(posedge clk);
    #1;
    startD = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(doneD), 32'd0);
    check("abort_result", result_divide, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    rst        = 1'b1;
    startD     = 1'b0;
    div_opcode = 2'b00;
    operand1   = 32'd0;
    operand2   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(doneD), 32'd0);
    check("reset_result", result_divide, 32'd0);
    rst = 1'b0;

    run_op(2'b00, 32'd100,        32'd7,        0, "div_100_7");
    run_op(2'b10, 32'hFFFF_FFF9,  32'd2,        0, "rem_m7_2");
    run_op(2'b00, 32'hFFFF_FFF9,  32'd2,        0, "div_m7_2");
    run_op(2'b01, 32'h1234_5678,  32'd0,        0, "divu_by0");
    run_op(2'b11, 32'h1234_5678,  32'd0,        0, "remu_by0");
    run_op(2'b00, 32'hFFFF_FFFB,  32'd0,        0, "div_neg_by0");
    run_op(2'b10, 32'hFFFF_FFFB,  32'd0,        0, "rem_neg_by0");
    run_op(2'b00, 32'h8000_0000,  32'hFFFF_FFFF, 0, "div_ovf");
    run_op(2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 0, "rem_ovf");
    run_op(2'b01, 32'hFFFF_FFFF,  32'd1,        0, "divu_max");
    run_op(2'b10, 32'd5,          32'hFFFF_FFF8, 0, "rem_small");
    run_op(2'b00, 32'd123456,     32'd321,      10, "start_ignored");

    reset_abort();
    run_op(2'b01, 32'd9, 32'd3, 0, "divu_9_3");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       begin
                   b = 32'($urandom_range(1, 255));
                   if ($urandom_range(0, 1) == 1) b = -b;
                 end
        3:       b = $urandom & 32'h0000_FFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, 0, "random");
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
